step_sequencer_core: RTL and testbench

//   Parametrised N-channel, S-step pattern sequencer generating square-wave tones; successor to the fixed 4-speaker/16-step player.

---
 rtl/seq_pkg.sv | 21 ++
 rtl/tone_gen.sv | 30 +++
 rtl/step_sequencer_core.sv | 124 ++++++++++++
 tb/tb_step_sequencer_core.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the step sequencer: FSM encoding, default sizes,
// system clock rate and half-period constants for common note pitches.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int unsigned DEF_NUM_CH    = 4;
    localparam int unsigned DEF_NUM_STEPS = 16;
    localparam int unsigned CLK_HZ        = 50_000_000;

    // Half-periods in 50 MHz clock cycles
    localparam logic [15:0] A880  = 16'd28409;
    localparam logic [15:0] C1046 = 16'd23900;
    localparam logic [15:0] D1147 = 16'd21796;
    localparam logic [15:0] F1396 = 16'd17908;

endpackage

// File: rtl/tone_gen.sv
// Gated square-wave generator: toggles wave every 'half' cycles while gate
// is high; counter and output are forced low on the edge after gate drops.
module tone_gen #(
    parameter int unsigned HALF_W = 16
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              gate,
    input  logic [HALF_W-1:0] half,
    output logic              wave
);

    logic [HALF_W-1:0] cnt;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt  <= '0;
            wave <= 1'b0;
        end else if (!gate) begin
            cnt  <= '0;
            wave <= 1'b0;
        end else if (cnt == half - HALF_W'(1)) begin
            cnt  <= '0;
            wave <= ~wave;
        end else begin
            cnt <= cnt + HALF_W'(1);
        end
    end

endmodule

// File: rtl/step_sequencer_core.sv
// N-channel, S-step pattern sequencer: pattern registers, tempo counter,
// shared step pointer and a play FSM gating one tone_gen per channel.
module step_sequencer_core
    import seq_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned NUM_STEPS = 16,
    parameter int unsigned DIV_W     = 28,
    parameter int unsigned HALF_W    = 16,
    parameter int unsigned CH_W      = 2,
    parameter int unsigned STEP_W    = 4
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     run,
    input  logic                     loop,
    input  logic [DIV_W-1:0]         tempo_div,
    input  logic [NUM_CH*HALF_W-1:0] tone_half,
    input  logic [NUM_CH-1:0]        mute,
    input  logic                     pat_we,
    input  logic [CH_W-1:0]          pat_ch,
    input  logic [NUM_STEPS-1:0]     pat_data,
    input  logic [CH_W-1:0]          rd_ch,
    output logic [NUM_STEPS-1:0]     rd_pattern,
    output logic [NUM_CH-1:0]        audio,
    output logic [STEP_W-1:0]        step_idx,
    output logic                     step_tick,
    output logic                     playing,
    output logic                     done
);

    seq_state_t           state_q, state_d;
    logic [DIV_W-1:0]     tempo_cnt;
    logic [DIV_W-1:0]     tempo_eff;
    logic                 tempo_expire;
    logic                 last_step;
    logic                 start;
    logic                 step_adv;
    logic [NUM_STEPS-1:0] pat_q [NUM_CH];
    logic [NUM_CH-1:0]    gate;

    assign tempo_eff    = (tempo_div == '0) ? DIV_W'(1) : tempo_div;
    // Equality compare lets a shrunk divisor run the counter through wrap
    assign tempo_expire = (tempo_cnt == tempo_eff - DIV_W'(1));
    assign last_step    = (step_idx == STEP_W'(NUM_STEPS - 1));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        step_adv = 1'b0;
        case (state_q)
            IDLE: if (run) begin
                state_d = PLAY;
                start   = 1'b1;
            end
            PLAY: begin
                if (!run)
                    state_d = IDLE;
                else if (tempo_expire) begin
                    if (last_step && !loop) state_d  = DONE;
                    else                    step_adv = 1'b1;
                end
            end
            DONE:    if (!run) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            tempo_cnt <= '0;
            step_idx  <= '0;
            step_tick <= 1'b0;
        end else if (start) begin
            tempo_cnt <= '0;
            step_idx  <= '0;
            step_tick <= 1'b0;
        end else if (state_q == PLAY && run) begin
            tempo_cnt <= tempo_expire ? '0 : tempo_cnt + DIV_W'(1);
            step_tick <= step_adv;
            if (step_adv)
                step_idx <= last_step ? '0 : step_idx + STEP_W'(1);
        end else begin
            step_tick <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int unsigned c = 0; c < NUM_CH; c++) pat_q[c] <= '0;
        end else if (pat_we) begin
            for (int unsigned c = 0; c < NUM_CH; c++)
                if (pat_ch == CH_W'(c)) pat_q[c] <= pat_data;
        end
    end

    always_comb begin
        rd_pattern = '0;
        for (int unsigned c = 0; c < NUM_CH; c++)
            if (rd_ch == CH_W'(c)) rd_pattern = pat_q[c];
    end

    assign playing = (state_q == PLAY);
    assign done    = (state_q == DONE);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign gate[g] = playing & pat_q[g][step_idx] & ~mute[g]
                         & (tone_half[g*HALF_W +: HALF_W] != '0);

        tone_gen #(.HALF_W(HALF_W)) u_tone (
            .clk    (clk),
            .resetN (resetN),
            .gate   (gate[g]),
            .half   (tone_half[g*HALF_W +: HALF_W]),
            .wave   (audio[g])
        );
    end

endmodule

// File: tb/tb_step_sequencer_core.sv
// Directed bench for step_sequencer_core; expectations are queued when the
// stimulus is applied and compared when the DUT output is sampled.
module tb_step_sequencer_core;

    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned NUM_STEPS = 16;
    localparam int unsigned DIV_W     = 28;
    localparam int unsigned HALF_W    = 16;
    localparam int unsigned CH_W      = 8;
    localparam int unsigned STEP_W    = 4;

    logic                     clk = 1'b0;
    logic                     resetN;
    logic                     run;
    logic                     loop;
    logic [DIV_W-1:0]         tempo_div;
    logic [NUM_CH*HALF_W-1:0] tone_half;
    logic [NUM_CH-1:0]        mute;
    logic                     pat_we;
    logic [CH_W-1:0]          pat_ch;
    logic [NUM_STEPS-1:0]     pat_data;
    logic [CH_W-1:0]          rd_ch;
    logic [NUM_STEPS-1:0]     rd_pattern;
    logic [NUM_CH-1:0]        audio;
    logic [STEP_W-1:0]        step_idx;
    logic                     step_tick;
    logic                     playing;
    logic                     done;

    step_sequencer_core #(
        .NUM_CH(NUM_CH), .NUM_STEPS(NUM_STEPS), .DIV_W(DIV_W),
        .HALF_W(HALF_W), .CH_W(CH_W), .STEP_W(STEP_W)
    ) dut (
        .clk(clk), .resetN(resetN), .run(run), .loop(loop),
        .tempo_div(tempo_div), .tone_half(tone_half), .mute(mute),
        .pat_we(pat_we), .pat_ch(pat_ch), .pat_data(pat_data),
        .rd_ch(rd_ch), .rd_pattern(rd_pattern), .audio(audio),
        .step_idx(step_idx), .step_tick(step_tick),
        .playing(playing), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic push(input string tag, input logic [31:0] e);
        sb.push_back('{tag, e});
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t x;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed %0h required an entry", obs);
        end else begin
            x = sb.pop_front();
            assert (obs === x.exp) else begin
                miscompares++;
                $error("FAIL %s: observed %0h expected %0h", x.tag, obs, x.exp);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_row(input logic [CH_W-1:0] ch, input logic [NUM_STEPS-1:0] d);
        pat_we   = 1'b1;
        pat_ch   = ch;
        pat_data = d;
        tick(1);
        pat_we   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN    = 1'b0;
        run       = 1'b0;
        loop      = 1'b0;
        tempo_div = '0;
        tone_half = '0;
        mute      = '0;
        pat_we    = 1'b0;
        pat_ch    = '0;
        pat_data  = '0;
        rd_ch     = '0;
        tick(3);
        push("rst_playing", 32'd0); chk(32'(playing));
        push("rst_step",    32'd0); chk(32'(step_idx));
        push("rst_audio",   32'd0); chk(32'(audio));
        #2 resetN = 1'b1;
        tick(1);

        // ---- loop play, tempo 10, ch0 half-period 3 on step 0 ----
        pat_we = 1'b1; pat_ch = 8'd0; pat_data = 16'h0001; rd_ch = 8'd0;
        push("wr_old_row0", 32'h0); chk(32'(rd_pattern));
        tick(1);
        pat_we = 1'b0;
        push("wr_new_row0", 32'h0001); chk(32'(rd_pattern));

        tempo_div = 28'd10;
        tone_half[0 +: HALF_W] = 16'd3;
        loop = 1'b1;
        run  = 1'b1;
        tick(1);
        push("play_entry", 32'd1); chk(32'(playing));
        push("entry_step", 32'd0); chk(32'(step_idx));
        for (int k = 1; k <= 12; k++) begin
            push("t2_audio0", ((k >= 3 && k <= 5) || (k >= 9 && k <= 10)) ? 32'd1 : 32'd0);
            push("t2_tick",   (k == 10) ? 32'd1 : 32'd0);
            push("t2_step",   (k >= 10) ? 32'd1 : 32'd0);
            tick(1);
            chk(32'(audio[0]));
            chk(32'(step_tick));
            chk(32'(step_idx));
        end
        push("pre_wrap_step", 32'd15); push("pre_wrap_tick", 32'd0);
        tick(147);
        chk(32'(step_idx)); chk(32'(step_tick));
        push("wrap_step", 32'd0); push("wrap_tick", 32'd1);
        tick(1);
        chk(32'(step_idx)); chk(32'(step_tick));
        push("wrap_audio_e2", 32'd0);
        tick(2);
        chk(32'(audio[0]));
        push("wrap_audio_e3", 32'd1);
        tick(1);
        chk(32'(audio[0]));

        // ---- asynchronous reset while a note is sounding ----
        resetN = 1'b0;
        #1;
        push("arst_audio",   32'd0); chk(32'(audio));
        push("arst_playing", 32'd0); chk(32'(playing));
        push("arst_done",    32'd0); chk(32'(done));
        push("arst_step",    32'd0); chk(32'(step_idx));
        push("arst_tick",    32'd0); chk(32'(step_tick));
        for (int c = 0; c < 4; c++) begin
            rd_ch = 8'(c);
            #1;
            push("arst_row", 32'd0); chk(32'(rd_pattern));
        end
        run    = 1'b0;
        resetN = 1'b1;
        tick(1);

        // ---- one-shot, tempo 4 ----
        write_row(8'd0, 16'h0001);
        tempo_div = 28'd4;
        loop = 1'b0;
        run  = 1'b1;
        tick(1);
        push("os_playing", 32'd1); chk(32'(playing));
        push("os_audio_e3", 32'd1);
        tick(3);
        chk(32'(audio[0]));
        push("os_step_e4", 32'd1); push("os_tick_e4", 32'd1);
        tick(1);
        chk(32'(step_idx)); chk(32'(step_tick));
        push("os_step_e63", 32'd15); push("os_done_e63", 32'd0); push("os_play_e63", 32'd1);
        tick(59);
        chk(32'(step_idx)); chk(32'(done)); chk(32'(playing));
        push("os_done", 32'd1); push("os_play_off", 32'd0);
        push("os_step_hold", 32'd15); push("os_audio_off", 32'd0);
        tick(1);
        chk(32'(done)); chk(32'(playing)); chk(32'(step_idx)); chk(32'(audio));
        push("os_done_stays", 32'd1);
        tick(2);
        chk(32'(done));
        run = 1'b0;
        push("os_idle_done", 32'd0); push("os_idle_play", 32'd0);
        tick(1);
        chk(32'(done)); chk(32'(playing));

        // ---- tempo_div 0: advance every cycle; silent ch1 ----
        write_row(8'd1, 16'hFFFF);
        tempo_div = '0;
        loop = 1'b1;
        run  = 1'b1;
        tick(1);
        for (int k = 1; k <= 20; k++) begin
            push("fast_step",   32'(k % 16));
            push("fast_tick",   32'd1);
            push("fast_audio1", 32'd0);
            tick(1);
            chk(32'(step_idx)); chk(32'(step_tick)); chk(32'(audio[1]));
        end
        run = 1'b0;
        push("fast_stop", 32'd0);
        tick(1);
        chk(32'(playing));

        // ---- live row rewrite and out-of-range channel ----
        tone_half[2*HALF_W +: HALF_W] = 16'd2;
        tempo_div = 28'd10;
        run = 1'b1;
        tick(1);
        push("live_step1", 32'd1); push("live_audio2_off", 32'd0);
        tick(11);
        chk(32'(step_idx)); chk(32'(audio[2]));
        pat_we = 1'b1; pat_ch = 8'd2; pat_data = 16'hAAAA; rd_ch = 8'd2;
        #1;
        push("live_rd_old", 32'h0); chk(32'(rd_pattern));
        tick(1);
        pat_we = 1'b0;
        push("live_rd_new", 32'hAAAA); chk(32'(rd_pattern));
        push("live_audio2_e1", 32'd0);
        tick(1);
        chk(32'(audio[2]));
        push("live_audio2_e2", 32'd1);
        tick(1);
        chk(32'(audio[2]));
        write_row(8'd5, 16'h1234);
        rd_ch = 8'd0; #1; push("inv_row0", 32'h0001); chk(32'(rd_pattern));
        rd_ch = 8'd1; #1; push("inv_row1", 32'hFFFF); chk(32'(rd_pattern));
        rd_ch = 8'd2; #1; push("inv_row2", 32'hAAAA); chk(32'(rd_pattern));
        rd_ch = 8'd3; #1; push("inv_row3", 32'h0000); chk(32'(rd_pattern));
        rd_ch = 8'd5; #1; push("inv_rd5",  32'h0000); chk(32'(rd_pattern));
        run = 1'b0;
        tick(1);

        // ---- mute ch0 mid-note, ch3 keeps sounding ----
        write_row(8'd3, 16'hFFFF);
        tone_half[3*HALF_W +: HALF_W] = 16'd5;
        run = 1'b1;
        tick(1);
        push("mute_before", 32'b0001);
        tick(4);
        chk(32'(audio));
        mute = 4'b0001;
        push("mute_after", 32'b1000);
        tick(1);
        chk(32'(audio));
        run  = 1'b0;
        mute = '0;
        tick(2);

        if (sb.size() != 0) begin
            miscompares++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
